// File: rtl/sm_cfg_loader.sv
// sm_cfg_loader: serial configuration loader for the 5x5x4x4 switch matrix.
// Shifts a 108-bit frame into a shadow store, checks all 18 route words in
// order, and either commits the frame atomically to cfg_bus or reports the
// first illegal entry while leaving the live routing untouched.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_start           begin/restart a frame load (wins over a same-cycle bit)
//   cfg_bit, cfg_valid  serial data and qualifier (accepted with cfg_ready)
//   cfg_ready           high only while shifting
//   busy                loader not idle
//   cfg_done            one-cycle pulse on commit
//   cfg_active          sticky: some frame has been committed
//   cfg_err             last frame rejected (cleared by cfg_start)
//   err_code, err_entry 1=bad side, 2=index out of range, 3=self-loop; entry no.
//   cfg_bus             live routing, entry e at [6e+5:6e]
module sm_cfg_loader #(
  parameter int unsigned N_TB = 5,
  parameter int unsigned N_LR = 4,
  parameter int unsigned W    = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic                         cfg_bit,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  output logic                         busy,
  output logic                         cfg_done,
  output logic                         cfg_active,
  output logic                         cfg_err,
  output logic [1:0]                   err_code,
  output logic [4:0]                   err_entry,
  output logic [(2*N_TB+2*N_LR)*W-1:0] cfg_bus
);

  localparam int unsigned N_ENT = 2*N_TB + 2*N_LR;
  localparam int unsigned BUS_W = N_ENT * W;
  localparam int unsigned IW    = $clog2(BUS_W);
  localparam int unsigned EW    = 5;
  localparam int unsigned PW    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_COMMIT,
    S_ERROR
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [BUS_W-1:0] shadow;
  logic [EW-1:0]    ent_cnt;
  logic [PW-1:0]    pos_cnt;
  logic [EW-1:0]    chk_cnt;
  logic             v_vld;
  logic [1:0]       v_code;
  logic [EW-1:0]    v_entry;

  logic             accept_c;
  logic             last_bit_c;
  logic [IW-1:0]    wr_idx_c;
  logic [IW-1:0]    chk_base_c;
  logic [W-1:0]     chk_word_c;
  logic [2:0]       sel_c;
  logic [2:0]       idx_c;
  logic [EW-1:0]    src_c;
  logic [1:0]       code_c;

  // Serial write position: entry-major, MSB of each word first
  always_comb begin
    accept_c   = (state == S_SHIFT) && cfg_valid && !cfg_start;
    last_bit_c = accept_c && (ent_cnt == EW'(N_ENT-1)) && (pos_cnt == PW'(W-1));
    wr_idx_c   = IW'(ent_cnt) * IW'(W) + IW'(W-1) - IW'(pos_cnt);
  end

  // Legality of the entry selected by chk_cnt
  always_comb begin
    chk_base_c = IW'(chk_cnt) * IW'(W);
    chk_word_c = shadow[chk_base_c +: W];
    sel_c      = chk_word_c[2:0];
    idx_c      = chk_word_c[5:3];
    src_c      = '0;
    code_c     = 2'd0;
    case (sel_c)
      3'd1:    src_c = EW'(idx_c);
      3'd2:    src_c = EW'(idx_c) + EW'(2*N_TB+N_LR);
      3'd3:    src_c = EW'(idx_c) + EW'(N_TB);
      3'd4:    src_c = EW'(idx_c) + EW'(2*N_TB);
      default: src_c = '0;
    endcase
    if (sel_c > 3'd4) begin
      code_c = 2'd1;
    end else if (((sel_c == 3'd1) || (sel_c == 3'd3)) && (idx_c >= 3'(N_TB))) begin
      code_c = 2'd2;
    end else if (((sel_c == 3'd2) || (sel_c == 3'd4)) && (idx_c >= 3'(N_LR))) begin
      code_c = 2'd2;
    end else if ((sel_c != 3'd0) && (src_c == chk_cnt)) begin
      code_c = 2'd3;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; checking decides on the registered verdict (v_*)
  always_comb begin
    state_nxt = state;
    if (cfg_start) begin
      state_nxt = S_SHIFT;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_IDLE;
        S_SHIFT:  if (last_bit_c) state_nxt = S_CHECK;
        S_CHECK: begin
          if (v_vld && (v_code != 2'd0)) begin
            state_nxt = S_ERROR;
          end else if (v_vld && (v_entry == EW'(N_ENT-1))) begin
            state_nxt = S_COMMIT;
          end
        end
        S_COMMIT: state_nxt = S_IDLE;
        S_ERROR:  state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      ent_cnt    <= '0;
      pos_cnt    <= '0;
      chk_cnt    <= '0;
      v_vld      <= 1'b0;
      v_code     <= 2'd0;
      v_entry    <= '0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_active <= 1'b0;
      cfg_err    <= 1'b0;
      err_code   <= 2'd0;
      err_entry  <= '0;
      cfg_bus    <= '0;
    end else begin
      cfg_ready <= (state_nxt == S_SHIFT);
      busy      <= (state_nxt != S_IDLE);
      cfg_done  <= 1'b0;
      if (cfg_start) begin
        shadow    <= '0;
        ent_cnt   <= '0;
        pos_cnt   <= '0;
        chk_cnt   <= '0;
        v_vld     <= 1'b0;
        cfg_err   <= 1'b0;
        err_code  <= 2'd0;
        err_entry <= '0;
      end else begin
        case (state)
          S_SHIFT: begin
            if (accept_c) begin
              shadow[wr_idx_c] <= cfg_bit;
              if (last_bit_c) begin
                ent_cnt <= '0;
                pos_cnt <= '0;
                chk_cnt <= '0;
                v_vld   <= 1'b0;
              end else if (pos_cnt == PW'(W-1)) begin
                pos_cnt <= '0;
                ent_cnt <= ent_cnt + EW'(1);
              end else begin
                pos_cnt <= pos_cnt + PW'(1);
              end
            end
          end
          S_CHECK: begin
            if (chk_cnt < EW'(N_ENT)) begin
              v_vld   <= 1'b1;
              v_code  <= code_c;
              v_entry <= chk_cnt;
              chk_cnt <= chk_cnt + EW'(1);
            end
            if (state_nxt == S_ERROR) begin
              err_code  <= v_code;
              err_entry <= v_entry;
            end
          end
          S_COMMIT: begin
            cfg_bus    <= shadow;
            cfg_done   <= 1'b1;
            cfg_active <= 1'b1;
          end
          S_ERROR: cfg_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_cfg_loader.sv
// Testbench for sm_cfg_loader: frames are driven serially, the expected
// outcome of each completed frame is queued, and a negedge monitor pops and
// compares whenever the DUT commits or raises an error.
module tb_sm_cfg_loader;

  logic         clk;
  logic         rst;
  logic         cfg_start;
  logic         cfg_bit;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         busy;
  logic         cfg_done;
  logic         cfg_active;
  logic         cfg_err;
  logic [1:0]   err_code;
  logic [4:0]   err_entry;
  logic [107:0] cfg_bus;

  sm_cfg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_active(cfg_active),
    .cfg_err   (cfg_err),
    .err_code  (err_code),
    .err_entry (err_entry),
    .cfg_bus   (cfg_bus)
  );

  typedef struct {
    bit           is_err;
    logic [1:0]   code;
    logic [4:0]   entry;
    logic [107:0] bus;
    int           start;
    bit           timed;
  } exp_t;

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  logic [5:0]   fw[18];
  logic [107:0] live     = '0;
  logic         err_q    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference rules: first illegal entry wins; sides map to pin rows
  function automatic void model(output bit is_err, output logic [1:0] code, output logic [4:0] entry);
    int sel, idx, lim, pin;
    is_err = 0; code = 0; entry = 0;
    for (int e = 0; e < 18; e++) begin
      sel = int'(fw[e][2:0]);
      idx = int'(fw[e][5:3]);
      lim = (sel == 1 || sel == 3) ? 5 : 4;
      case (sel)
        1: pin = idx;        // top
        3: pin = 5 + idx;    // bottom
        4: pin = 10 + idx;   // left
        2: pin = 14 + idx;   // right
        default: pin = -1;
      endcase
      if (sel > 4) begin
        is_err = 1; code = 2'd1; entry = 5'(e); return;
      end else if (sel != 0 && idx >= lim) begin
        is_err = 1; code = 2'd2; entry = 5'(e); return;
      end else if (sel != 0 && pin == e) begin
        is_err = 1; code = 2'd3; entry = 5'(e); return;
      end
    end
  endfunction

  function automatic logic [107:0] pack_frame();
    logic [107:0] b;
    for (int e = 0; e < 18; e++) b[6*e +: 6] = fw[e];
    return b;
  endfunction

  // Drive a frame of fw[]; n_bits < 108 leaves it unfinished
  task automatic send_frame(input int n_bits, input bit gaps);
    logic [107:0] b;
    exp_t         x;
    int           st;
    b = pack_frame();
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_valid = 1'($urandom_range(0, 1));
    cfg_bit   = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1 st = cyc;
    for (int k = 0; k < n_bits; k++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          cfg_valid = 1'b0;
          cfg_bit   = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      cfg_valid = 1'b1;
      cfg_bit   = b[6*(k/6) + 5 - (k%6)];
      @(posedge clk);
    end
    if (n_bits == 108) begin
      model(x.is_err, x.code, x.entry);
      x.bus   = x.is_err ? live : b;
      x.start = st;
      x.timed = !gaps;
      if (!x.is_err) live = b;
      sb.push_back(x);
    end
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_idle: got busy=%0b pending=%0d expected idle with 0 pending", busy, sb.size());
    end
  endtask

  task automatic clear_fw();
    for (int e = 0; e < 18; e++) fw[e] = 6'd0;
  endtask

  task automatic set_t2();
    clear_fw();
    fw[0]  = 6'b010_100;
    fw[15] = 6'b100_011;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge
  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_bus", cfg_bus, '0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_active", cfg_active, 0);
    chk("rst_err", cfg_err, 0);
    sb.delete();
    live = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pop an expectation on every commit pulse or new error
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      err_q = 1'b0;
    end else begin
      if (cfg_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("done_kind", 0, x.is_err);
          chk("done_bus", cfg_bus, x.bus);
          chk("done_active", cfg_active, 1);
          if (x.timed) chk("done_latency", cyc - x.start, 128);
        end
      end
      if (cfg_err && !err_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_err", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("err_kind", 1, x.is_err);
          chk("err_code", err_code, x.code);
          chk("err_entry", err_entry, x.entry);
          chk("err_bus", cfg_bus, x.bus);
        end
      end
      err_q = cfg_err;
    end
  end

  initial begin
    logic [107:0] t2;
    int           r, s;
    t2 = '0;
    t2[5:0]   = 6'b010100;
    t2[95:90] = 6'b100011;
    rst = 1'b1; cfg_start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    clear_fw();
    #1;
    chk("init_bus", cfg_bus, '0);
    chk("init_busy", busy, 0);
    chk("init_done", cfg_done, 0);
    chk("init_code", err_code, 0);
    chk("init_entry", err_entry, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Good frame, gapless
    set_t2();
    send_frame(108, 0);
    wait_idle();
    chk("t2_bus", cfg_bus, t2);
    chk("t2_active", cfg_active, 1);
    chk("t2_err", cfg_err, 0);

    // Mid-cycle reset over live config, then reload
    mid_reset();
    set_t2();
    send_frame(108, 0);
    wait_idle();
    chk("t1_reload_bus", cfg_bus, t2);

    // Error codes, each over the T2 configuration
    clear_fw(); fw[7] = {3'd0, 3'd5};
    send_frame(108, 0); wait_idle();
    chk("t3a_err", cfg_err, 1); chk("t3a_code", err_code, 1);
    chk("t3a_entry", err_entry, 7); chk("t3a_bus", cfg_bus, t2);
    clear_fw(); fw[10] = {3'd4, 3'd2};
    send_frame(108, 0); wait_idle();
    chk("t3b_code", err_code, 2); chk("t3b_entry", err_entry, 10);
    chk("t3b_bus", cfg_bus, t2);
    clear_fw(); fw[3] = {3'd3, 3'd1};
    send_frame(108, 0); wait_idle();
    chk("t3c_code", err_code, 3); chk("t3c_entry", err_entry, 3);
    chk("t3c_bus", cfg_bus, t2);

    // First failing entry wins
    clear_fw(); fw[2] = {3'd2, 3'd1}; fw[9] = {3'd0, 3'd7};
    send_frame(108, 0); wait_idle();
    chk("t4_code", err_code, 3); chk("t4_entry", err_entry, 2);
    chk("t4_active", cfg_active, 1);

    // Stalls, then abort at bit 50 followed by a full frame
    set_t2();
    send_frame(108, 1); wait_idle();
    chk("t5_gap_bus", cfg_bus, t2);
    chk("t5_gap_err", cfg_err, 0);
    clear_fw(); fw[4] = 6'b111_111;
    send_frame(50, 0);
    set_t2();
    send_frame(108, 0); wait_idle();
    chk("t5_abort_bus", cfg_bus, t2);

    // Reset at bit 60 over live config
    set_t2();
    send_frame(60, 0);
    mid_reset();
    set_t2();
    send_frame(108, 0); wait_idle();
    chk("t6_bus", cfg_bus, t2);

    // Randomized frames against the reference rules
    for (int f = 0; f < 30; f++) begin
      for (int e = 0; e < 18; e++) begin
        r = $urandom_range(0, 19);
        if (r == 0) begin
          fw[e] = 6'($urandom);
        end else if (r < 6) begin
          fw[e] = 6'd0;
        end else begin
          s = $urandom_range(1, 4);
          fw[e] = {3'($urandom_range(0, (s == 1 || s == 3) ? 4 : 3)), 3'(s)};
        end
      end
      send_frame(108, 1'($urandom_range(0, 1)));
      wait_idle();
    end

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
